kernel_sysid_arbiter: RTL
=========================

KERNEL_SYSID_ARBITER -- requirements
Module: kernel_sysid_arbiter

Interface
REQ-001 Parameter FIXED_PRIO, default 0: 0 = round-robin arbitration; 1 = m0 always wins on contention.
REQ-002 Port clock, input, 1: single clock; all state SHALL change on its rising edge.
REQ-003 Port reset, input, 1: asynchronous, active-high reset.
REQ-004 Ports m0_read and m1_read, input, 1 each: read request, held by the master until accepted.
REQ-005 Ports m0_address and m1_address, input, 1 each: 0 selects the ID word, 1 selects the timestamp word.
REQ-006 Ports m0_waitrequest and m1_waitrequest, output, 1 each: high means the request is not yet accepted.
REQ-007 Ports m0_readdata and m1_readdata, output, 32 each: read response data.
REQ-008 Ports m0_readdatavalid and m1_readdatavalid, output, 1 each: one-cycle response strobe.
REQ-009 Port sys_address, output, 1: address driven to the combinational sysid slave.
REQ-010 Port sys_read, output, 1: strobe, high in each cycle the slave is sampled.
REQ-011 Port sys_readdata, input, 32: combinational data from the sysid slave.

Function
REQ-012 The state machine SHALL have the states IDLE, ACCESS and RESP.
REQ-013 IDLE: if any mX_read is high, the block SHALL latch the winner and its address, then go to ACCESS; otherwise it stays in IDLE.
REQ-014 Round-robin mode: on contention the master not granted last SHALL win; a lone requester always wins.
REQ-015 The last-grant register SHALL reset to m1, so m0 wins the first contention.
REQ-016 ACCESS: the block SHALL drive sys_address from the latched address, assert sys_read, capture sys_readdata, deassert the winner's waitrequest for exactly this cycle, then go to RESP.
REQ-017 RESP: the winner's readdatavalid SHALL be high for one cycle with the captured data on its readdata, then the state returns to IDLE.
REQ-018 Latency: a read first seen in IDLE at cycle N SHALL give waitrequest low at N+1 and readdatavalid at N+2.
REQ-019 Throughput is at most one read per 3 cycles.
REQ-020 A waiting master's waitrequest SHALL stay high until its ACCESS cycle; the losing master is served next.
REQ-021 mX_readdata SHALL hold its last value when readdatavalid is low.
REQ-022 The non-winner's readdatavalid SHALL stay low in RESP.
REQ-023 sys_read SHALL be low outside ACCESS, and sys_address SHALL hold its last value.
REQ-024 In IDLE, a read that drops before acceptance SHALL be ignored; a read dropped after IDLE latched it SHALL still complete normally.

Reset
REQ-025 Reset SHALL force state IDLE, all waitrequest outputs high, all readdatavalid outputs low, readdata 0, sys_read 0, sys_address 0 and last-grant m1.
REQ-026 Reset asserted mid-transaction SHALL abort it with no readdatavalid pulse; the master re-issues its read after reset.
REQ-027 Reset SHALL clear all cache valid bits when the cache is compiled in.

Configuration
REQ-028 Macro SYSID_ARB_CACHE_EN, when defined, SHALL add a two-entry cache (ID, timestamp), each entry with a valid bit.
REQ-029 With SYSID_ARB_CACHE_EN, an entry SHALL be filled on its first ACCESS.
REQ-030 With SYSID_ARB_CACHE_EN, later hits SHALL follow identical handshake timing with sys_read held low, data supplied from the cache.
REQ-031 Without SYSID_ARB_CACHE_EN, there SHALL be no cache logic, and every accepted read asserts sys_read exactly once.

Verification
REQ-032 m0_read=1, m0_address=0 from cycle 0, sys_readdata for address 0 = 0x00000000 -> m0_waitrequest low at cycle 1, m0_readdatavalid at cycle 2, m0_readdata=0x00000000.
REQ-033 m1_read=1, address 1, slave returns 0x582B5D63 -> m1_readdata=0x582B5D63 at cycle 2; m0 outputs stay idle.
REQ-034 Both masters request continuously with FIXED_PRIO=0 -> grants alternate m0, m1, m0, m1, with readdatavalid at cycles 2, 5, 8, 11.
REQ-035 Both masters request continuously with FIXED_PRIO=1 -> only m0 is served; m1_waitrequest stays high.
REQ-036 Reset pulsed during ACCESS -> no readdatavalid; all waitrequest outputs high; the next read completes with standard latency.
REQ-037 SYSID_ARB_CACHE_EN defined, 4 reads of address 1 -> sys_read pulses once, and all 4 responses equal 0x582B5D63.

Source files
------------

// File: rtl/kernel_sysid_arbiter.sv
// Two-master arbiter in front of a combinational sysid slave (ID / timestamp).
// Optional SYSID_ARB_CACHE_EN adds a two-entry response cache.
module kernel_sysid_arbiter #(
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        m0_read,
  input  logic        m0_address,
  output logic        m0_waitrequest,
  output logic [31:0] m0_readdata,
  output logic        m0_readdatavalid,
  input  logic        m1_read,
  input  logic        m1_address,
  output logic        m1_waitrequest,
  output logic [31:0] m1_readdata,
  output logic        m1_readdatavalid,
  output logic        sys_address,
  output logic        sys_read,
  input  logic [31:0] sys_readdata
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t      state_q, state_d;
  logic        winner_q, winner_d;
  logic        last_q, last_d;
  logic        addr_q, addr_d;
  logic [31:0] fetch;
  logic [31:0] m0_data_q, m1_data_q;

  always_comb begin
    state_d  = state_q;
    winner_d = winner_q;
    last_d   = last_q;
    addr_d   = addr_q;
    unique case (state_q)
      IDLE: begin
        if (m0_read | m1_read) begin
          if (m0_read & m1_read)
            winner_d = FIXED_PRIO ? 1'b0 : ~last_q;
          else
            winner_d = m1_read;
          last_d  = winner_d;
          addr_d  = winner_d ? m1_address : m0_address;
          state_d = ACCESS;
        end
      end
      ACCESS:  state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

`ifdef SYSID_ARB_CACHE_EN
  logic [1:0]  cache_vld_q;
  logic [31:0] cache_q [2];
  logic        hit;

  assign hit      = cache_vld_q[addr_q];
  assign fetch    = hit ? cache_q[addr_q] : sys_readdata;
  assign sys_read = (state_q == ACCESS) & ~hit;

  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      cache_vld_q <= 2'b00;
    else if (sys_read)
      cache_vld_q[addr_q] <= 1'b1;
  end

  // Data array needs no reset; valid bits gate every use.
  always_ff @(posedge clock) begin
    if (sys_read)
      cache_q[addr_q] <= sys_readdata;
  end
`else
  assign fetch    = sys_readdata;
  assign sys_read = (state_q == ACCESS);
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      winner_q  <= 1'b0;
      last_q    <= 1'b1;
      addr_q    <= 1'b0;
      m0_data_q <= '0;
      m1_data_q <= '0;
    end else begin
      state_q  <= state_d;
      winner_q <= winner_d;
      last_q   <= last_d;
      addr_q   <= addr_d;
      if (state_q == ACCESS) begin
        if (winner_q)
          m1_data_q <= fetch;
        else
          m0_data_q <= fetch;
      end
    end
  end

  assign sys_address      = addr_q;
  assign m0_readdata      = m0_data_q;
  assign m1_readdata      = m1_data_q;
  assign m0_waitrequest   = !((state_q == ACCESS) && !winner_q);
  assign m1_waitrequest   = !((state_q == ACCESS) && winner_q);
  assign m0_readdatavalid = (state_q == RESP) && !winner_q;
  assign m1_readdatavalid = (state_q == RESP) && winner_q;

endmodule
